// File: rtl/fpu_pkg.sv
// Shared FPU definitions: bf16 layout, constants and the int->bf16 converter state type.
package fpu_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

  localparam int unsigned BF16_BIAS = 127;
  localparam logic [15:0] BF16_ZERO = 16'h0000;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_INF  = 16'h7F80;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StDone
  } conv_state_e;

endpackage

// File: rtl/bf16_round_rne.sv
// Round-to-nearest-even on a 7-bit bf16 mantissa using one guard bit and a sticky bit.
// A mantissa carry-out wraps the fraction to zero and bumps the exponent.
module bf16_round_rne (
  input  logic [6:0] man_i,
  input  logic       guard_i,
  input  logic       sticky_i,
  input  logic [7:0] exp_i,
  output logic [7:0] exp_o,
  output logic [6:0] man_o
);

  logic       inc;
  logic [7:0] man_sum;

  // Round up above half, or at exactly half when the kept LSB is odd
  always_comb begin
    inc     = guard_i & (sticky_i | man_i[0]);
    man_sum = {1'b0, man_i} + {7'd0, inc};
    man_o   = man_sum[6:0];
    exp_o   = exp_i;
    if (man_sum[7]) begin
      man_o = 7'd0;
      exp_o = exp_i + 8'd1;
    end
  end

endmodule

// File: rtl/int_to_bf16.sv
// Iterative integer to bfloat16 converter, one leading-zero normalisation step per cycle.
// Optional macro FP_CONV_UNSIGNED_EN adds is_unsigned_i to treat the operand as unsigned.
module int_to_bf16
  import fpu_pkg::*;
#(
  parameter int unsigned INT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
`ifdef FP_CONV_UNSIGNED_EN
  input  logic             is_unsigned_i,
`endif
  output logic             in_ready_o,
  input  logic [INT_W-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      out_data_o
);

  // Exponent of a value whose leading one sits in the operand MSB
  localparam logic [7:0] ExpInit = 8'(BF16_BIAS + INT_W - 1);

  conv_state_e state_q, state_d;

  logic             sign_q, sign_d;
  logic [INT_W-1:0] mag_q, mag_d;
  logic [7:0]       exp_q, exp_d;
  bf16_t            res_q, res_d;

  logic             op_unsigned;
  logic             op_neg;
  logic [INT_W-1:0] op_mag;

  // Mantissa/guard/sticky window below the leading one, zero-padded so narrow INT_W works
  logic [INT_W+8:0] rnd_win;
  logic [6:0]       rnd_man_in;
  logic             rnd_guard;
  logic             rnd_sticky;
  logic [7:0]       rnd_exp;
  logic [6:0]       rnd_man;

`ifdef FP_CONV_UNSIGNED_EN
  assign op_unsigned = is_unsigned_i;
`else
  assign op_unsigned = 1'b0;
`endif

  // Operand sign and magnitude; the most negative value maps to 2^(INT_W-1) unsigned
  always_comb begin
    op_neg = in_data_i[INT_W-1] & ~op_unsigned;
    op_mag = op_neg ? (~in_data_i + INT_W'(1)) : in_data_i;
  end

  // Rounding inputs taken from the normalised magnitude (MSB is the implicit one)
  always_comb begin
    rnd_win    = {mag_q[INT_W-2:0], 10'd0};
    rnd_man_in = rnd_win[INT_W+8 -: 7];
    rnd_guard  = rnd_win[INT_W+1];
    rnd_sticky = |rnd_win[INT_W:0];
  end

  bf16_round_rne u_round (
    .man_i    (rnd_man_in),
    .guard_i  (rnd_guard),
    .sticky_i (rnd_sticky),
    .exp_i    (exp_q),
    .exp_o    (rnd_exp),
    .man_o    (rnd_man)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          state_d = (op_mag == '0) ? StDone : StNorm;
        end
      end
      StNorm: begin
        if (mag_q[INT_W-1]) begin
          state_d = StRound;
        end
      end
      StRound: state_d = StDone;
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: capture, normalise, round
  always_comb begin
    sign_d = sign_q;
    mag_d  = mag_q;
    exp_d  = exp_q;
    res_d  = res_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          sign_d = op_neg;
          mag_d  = op_mag;
          exp_d  = ExpInit;
          if (op_mag == '0) begin
            res_d = BF16_ZERO;
          end
        end
      end
      StNorm: begin
        if (!mag_q[INT_W-1]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      StRound: begin
        res_d = '{sign: sign_q, exp: rnd_exp, man: rnd_man};
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      exp_q  <= 8'd0;
      res_q  <= BF16_ZERO;
    end else begin
      sign_q <= sign_d;
      mag_q  <= mag_d;
      exp_q  <= exp_d;
      res_q  <= res_d;
    end
  end

  // Handshake outputs
  always_comb begin
    in_ready_o  = (state_q == StIdle) && !rst_i;
    out_valid_o = (state_q == StDone);
    out_data_o  = res_q;
  end

endmodule

// File: tb/tb_int_to_bf16.sv
// Directed and randomized bench for int_to_bf16 against an arithmetic bf16 reference model.
module tb_int_to_bf16;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          is_uns;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  int_to_bf16 #(.INT_W(W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_valid_i    (in_valid),
`ifdef FP_CONV_UNSIGNED_EN
    .is_unsigned_i (is_uns),
`endif
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Integer magnitude of the operand as the spec interprets it
  function automatic longint unsigned ref_mag(input logic [W-1:0] d, input bit uns);
    if (!uns && d[W-1]) return (64'(1) << W) - 64'(d);
    return 64'(d);
  endfunction

  function automatic int ref_msb(input longint unsigned m);
    for (int i = 63; i >= 0; i--) if (m[i]) return i;
    return -1;
  endfunction

  // Value -> bf16 by dividing down to 8 significant bits and rounding the remainder RNE
  function automatic logic [15:0] ref_bf16(input logic [W-1:0] d, input bit uns);
    longint unsigned m, q, rem, half;
    bit s;
    int p, e;
    s = !uns && d[W-1];
    m = ref_mag(d, uns);
    if (m == 0) return 16'h0000;
    p = ref_msb(m);
    e = 127 + p;
    if (p >= 7) begin
      q   = m >> (p - 7);
      rem = m - (q << (p - 7));
      if (p >= 8) begin
        half = 64'(1) << (p - 8);
        if (rem > half || (rem == half && q[0])) q = q + 1;
      end
    end else begin
      q = m << (7 - p);
    end
    if (q == 256) begin
      q = 128;
      e = e + 1;
    end
    return {s, 8'(e), q[6:0]};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] d, input bit uns);
    longint unsigned m;
    m = ref_mag(d, uns);
    if (m == 0) return 1;
    return 3 + (W - 1 - ref_msb(m));
  endfunction

  // Full transaction: wait ready, present, time the result, optionally stall, then accept
  task automatic run_op(input string tag, input logic [W-1:0] d, input bit uns, input int hold);
    int cyc;
    logic [15:0] first;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      tick;
      cyc++;
    end
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    is_uns   = uns;
    tick;
    in_valid = 1'b0;
    in_data  = $urandom;
    is_uns   = 1'($urandom_range(0, 1));
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      tick;
      cyc++;
    end
    check({tag, ".lat"}, 32'(cyc), 32'(ref_lat(d, uns)));
    check({tag, ".data"}, 32'(out_data), 32'(ref_bf16(d, uns)));
    first = out_data;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      tick;
      check({tag, ".hold_data"}, 32'(out_data), 32'(first));
      check({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    is_uns    = 1'b0;
    out_ready = 1'b0;
    tick;
    tick;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.data", 32'(out_data), 32'h0000);
    check("rst.ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst.ready", 32'(in_ready), 32'd1);

    // Directed points with hand-derived results
    run_op("one", 32'd1, 1'b0, 0);
    check("one.const", 32'(ref_bf16(32'd1, 1'b0)), 32'h3F80);
    run_op("neg_one", 32'hFFFF_FFFF, 1'b0, 0);
    check("neg_one.const", 32'(ref_bf16(32'hFFFF_FFFF, 1'b0)), 32'hBF80);
    run_op("zero", 32'd0, 1'b0, 0);
    run_op("min_int", 32'h8000_0000, 1'b0, 0);
    check("min_int.const", 32'(ref_bf16(32'h8000_0000, 1'b0)), 32'hCF00);
    run_op("tie_even", 32'd257, 1'b0, 0);
    check("tie_even.const", 32'(ref_bf16(32'd257, 1'b0)), 32'h4380);
    run_op("tie_odd", 32'd259, 1'b0, 0);
    check("tie_odd.const", 32'(ref_bf16(32'd259, 1'b0)), 32'h4382);
    run_op("carry", 32'h7FFF_FFFF, 1'b0, 0);
    check("carry.const", 32'(ref_bf16(32'h7FFF_FFFF, 1'b0)), 32'h4F00);

    // Backpressure, then a back-to-back operand right after the handshake
    run_op("bp", 32'd100, 1'b0, 10);
    check("bp.b2b_ready", 32'(in_ready), 32'd1);
    run_op("two", 32'd2, 1'b0, 0);
    check("two.const", 32'(ref_bf16(32'd2, 1'b0)), 32'h4000);

    // Abort mid-normalisation
    in_valid = 1'b1;
    in_data  = 32'd1;
    is_uns   = 1'b0;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    check("abort.busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick;
    check("abort.rst_ready", 32'(in_ready), 32'd0);
    check("abort.rst_data", 32'(out_data), 32'h0000);
    rst = 1'b0;
    #1;
    check("abort.ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 40; i++) begin
      tick;
      if (out_valid) break;
    end
    check("abort.no_valid", 32'(out_valid), 32'd0);
    run_op("three", 32'd3, 1'b0, 0);
    check("three.const", 32'(ref_bf16(32'd3, 1'b0)), 32'h4040);

`ifdef FP_CONV_UNSIGNED_EN
    run_op("uns_max", 32'hFFFF_FFFF, 1'b1, 0);
    check("uns_max.const", 32'(ref_bf16(32'hFFFF_FFFF, 1'b1)), 32'h4F80);
    run_op("sgn_max", 32'hFFFF_FFFF, 1'b0, 0);
`endif

    // Randomized operands spread across magnitudes and signs
    for (int i = 0; i < 40; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = -d;
`ifdef FP_CONV_UNSIGNED_EN
      run_op("rand", d, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
`else
      run_op("rand", d, 1'b0, $urandom_range(0, 2));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/int_to_bf16.md
Name: int_to_bf16

Overview:
- Iterative signed-integer to bfloat16 converter for the FPU.
- Packs an integer into bf16 format, feeding the bf16 add/sub and classification datapath.
- One leading-zero bit is normalised per cycle. Rounding is round-to-nearest-even, with the same guard/sticky convention as the add/sub unit.
- Valid/ready handshakes on both the input and the output side.

Parameters:
- INT_W, 32, integer operand width in bits; legal range 8..64; the maximum exponent is 127+INT_W-1.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- in_valid_i  input  1  operand valid
- in_ready_o  output  1  block can accept an operand
- in_data_i  input  INT_W  two's-complement operand
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts the result
- out_data_o  output  16  bf16 result {sign, exp[7:0], man[6:0]}

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state IDLE, out_valid_o=0, out_data_o=16'h0000. in_ready_o=0 while rst_i is high.
- in_ready_o = (state==IDLE) && !rst_i. out_valid_o = (state==DONE).
- FSM states and transitions:
  - IDLE: on in_valid_i, capture sign=in_data_i[MSB] and mag=|in_data_i| as an unsigned INT_W value (the most negative integer yields 2^(INT_W-1)); set exp=127+INT_W-1.
    - If mag==0, go to DONE with result 16'h0000 (never -0).
    - Otherwise go to NORM.
  - NORM: if mag[MSB]==1, go to ROUND. Otherwise shift mag left by 1, decrement exp, and stay.
  - ROUND: man=mag[MSB-1:MSB-7], guard=mag[MSB-8], sticky=|mag[MSB-9:0].
    - Increment man when guard && (sticky || man[0]).
    - If man carries out of 7 bits, set man=0 and exp+1.
    - Register {sign,exp,man}, then go to DONE.
  - DONE: hold out_valid_o and out_data_o stable until out_ready_i, then go to IDLE.
- Latency from the accepting edge to out_valid_o: 3+lz cycles, where lz = leading zeros of mag. Zero operand: 1 cycle. Maximum: INT_W+2.
- Throughput: one operand in flight. A new operand can be accepted on the cycle after the DONE handshake.
- out_valid_o and out_ready_i in the same cycle complete the handshake. Changes on in_data_i outside the accepting edge are ignored.
- No overflow, Inf or NaN is possible: exp ≤ 127+INT_W ≤ 191.
- rst_i mid-conversion aborts the conversion. The next state is IDLE with outputs at reset values; the partial result is discarded.
- out_data_o holds its last value in IDLE/NORM/ROUND and is only meaningful when out_valid_o=1.

Optional Feature:
- Macro FP_CONV_UNSIGNED_EN.
- Defined: adds port is_unsigned_i (input, 1 bit), sampled with the operand. When set, in_data_i is unsigned, sign=0, mag=in_data_i, and the maximum exp is 127+INT_W.
- Undefined: the port is absent and the operand is always two's-complement.

Decomposition:
- fpu_pkg holds:
  - bf16_t packed struct {sign, exp[7:0], man[6:0]}
  - BF16_BIAS=127, BF16_ZERO=16'h0000
  - BF16_QNAN=16'h7FC0 and BF16_INF=16'h7F80, shared with the add/sub unit
  - the conv_state_e enum {IDLE, NORM, ROUND, DONE}
- One natural sub-module: bf16_round_rne. It is combinational, takes {man[6:0], guard, sticky, exp}, and returns the rounded {exp, man}. It is reusable by add/sub and any future multiplier.

Test Plan:
- in_data_i=1 -> 0x3F80 after 3+31=34 cycles; in_data_i=-1 -> 0xBF80.
- 0 -> 0x0000 one cycle after acceptance. 0x80000000 -> 0xCF00 after 3 cycles.
- Tie cases:
  - 257 -> 0x4380 (tie, even LSB, truncate).
  - 259 -> 0x4382 (tie, odd LSB, round up).
  - 0x7FFFFFFF -> 0x4F00 (mantissa carry into exponent).
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE. out_data_o stays stable and in_ready_o=0; on release, a back-to-back operand 2 is accepted the cycle after the handshake -> 0x4000.
- Assert rst_i for 1 cycle during NORM of operand 1 -> out_valid_o stays 0, in_ready_o=1 the cycle after reset; operand 3 -> 0x4040.
- With FP_CONV_UNSIGNED_EN defined: is_unsigned_i=1, in_data_i=0xFFFFFFFF -> 0x4F80; is_unsigned_i=0, same data -> 0xBF80.
